// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the sequential divider:
//   div_state_e - divider controller states (DIV_IDLE / DIV_BUSY / DIV_DONE)
//   DIV_WIDTH   - default operand width
//   DIV_ITER    - iterations per full-length divide
//   DIVZ_QUOT   - quotient value returned for a zero divisor (all ones)
// -----------------------------------------------------------------------------
package div_pkg;

    localparam int unsigned DIV_WIDTH = 32;
    localparam int unsigned DIV_ITER  = 32;

    localparam logic [DIV_WIDTH-1:0] DIVZ_QUOT = '1;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_abs_neg.sv
// -----------------------------------------------------------------------------
// div_abs_neg
// Combinational conditional two's-complement negate. Used to form operand
// magnitudes and to apply sign correction to the quotient and remainder.
// Ports:
//   din    [W-1:0]  value in
//   neg_en          1 = output -din, 0 = output din
//   dout   [W-1:0]  value out
// -----------------------------------------------------------------------------
module div_abs_neg #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] din,
    input  logic         neg_en,
    output logic [W-1:0] dout
);

    always_comb begin
        dout = din;
        if (neg_en) begin
            dout = (~din) + W'(1);
        end
    end

endmodule

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Multi-cycle radix-2 restoring divider for DIV/DIVU. The EX stage holds
// start while a divide sits in EX and stalls until done. The result is
// {remainder, quotient}: upper half feeds HI, lower half feeds LO.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous reset, active low
//   start          divide request, sampled only in IDLE (may stay high)
//   cancel         abort the operation in flight (exception/flush)
//   flag_unsigned  1 = DIVU, 0 = DIV; captured with the operands
//   operand1       dividend (rs)
//   operand2       divisor (rt)
//   result         {remainder, quotient}, held until the next completion
//   done           one-cycle completion pulse
//   busy           high in BUSY and DONE
//
// Build option:
//   SEQ_DIV_FAST_PATH_EN - when defined, a zero divisor or |op1| < |op2|
//   completes straight from the launch edge instead of iterating.
// -----------------------------------------------------------------------------
module seq_divider
    import div_pkg::*;
#(
    parameter int unsigned WIDTH      = DIV_WIDTH,
    parameter int unsigned ITER_CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 cancel,
    input  logic                 flag_unsigned,
    input  logic [WIDTH-1:0]     operand1,
    input  logic [WIDTH-1:0]     operand2,
    output logic [2*WIDTH-1:0]   result,
    output logic                 done,
    output logic                 busy
);

    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    div_state_e              state_q,  state_d;
    logic [ITER_CNT_W-1:0]   cnt_q,    cnt_d;
    logic [WIDTH-1:0]        rem_q,    rem_d;     // partial remainder
    logic [WIDTH-1:0]        dvd_q,    dvd_d;     // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0]        dsr_q,    dsr_d;     // divisor magnitude
    logic [WIDTH-1:0]        op1_q,    op1_d;     // original dividend for the zero-divisor result
    logic                    qneg_q,   qneg_d;
    logic                    rneg_q,   rneg_d;
    logic                    divz_q,   divz_d;
    logic [2*WIDTH-1:0]      result_q, result_d;
    logic                    done_q,   done_d;
    logic                    busy_q,   busy_d;

    // Operand magnitudes (negated only for signed negative inputs)
    logic             neg1_en, neg2_en;
    logic [WIDTH-1:0] mag1, mag2;

    assign neg1_en = ~flag_unsigned & operand1[WIDTH-1];
    assign neg2_en = ~flag_unsigned & operand2[WIDTH-1];

    div_abs_neg #(.W(WIDTH)) u_abs_op1 (.din(operand1), .neg_en(neg1_en), .dout(mag1));
    div_abs_neg #(.W(WIDTH)) u_abs_op2 (.din(operand2), .neg_en(neg2_en), .dout(mag2));

    // One restoring iteration
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   trial;
    logic             qbit;
    logic [WIDTH-1:0] rem_iter;
    logic [WIDTH-1:0] dvd_iter;

    always_comb begin
        rem_shift = {rem_q, dvd_q[WIDTH-1]};
        trial     = rem_shift - {1'b0, dsr_q};
        qbit      = ~trial[WIDTH];
        rem_iter  = qbit ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        dvd_iter  = {dvd_q[WIDTH-2:0], qbit};
    end

    // Sign correction of the final iteration's outputs
    logic [WIDTH-1:0] quot_fix, rem_fix;

    div_abs_neg #(.W(WIDTH)) u_fix_quot (.din(dvd_iter), .neg_en(qneg_q), .dout(quot_fix));
    div_abs_neg #(.W(WIDTH)) u_fix_rem  (.din(rem_iter), .neg_en(rneg_q), .dout(rem_fix));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        dvd_d    = dvd_q;
        dsr_d    = dsr_q;
        op1_d    = op1_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        divz_d   = divz_q;
        result_d = result_q;
        done_d   = 1'b0;
        busy_d   = busy_q;

        case (state_q)
            DIV_IDLE: begin
                busy_d = 1'b0;
                if (start && !cancel) begin
                    state_d = DIV_BUSY;
                    busy_d  = 1'b1;
                    op1_d   = operand1;
                    dvd_d   = mag1;
                    dsr_d   = mag2;
                    // Sign flags are pre-gated by signedness so DIVU needs no extra flop
                    qneg_d  = ~flag_unsigned & (operand1[WIDTH-1] ^ operand2[WIDTH-1]);
                    rneg_d  = ~flag_unsigned & operand1[WIDTH-1];
                    divz_d  = (operand2 == '0);
                    rem_d   = '0;
                    cnt_d   = ITER_CNT_W'(WIDTH);
`ifdef SEQ_DIV_FAST_PATH_EN
                    if ((operand2 == '0) || (mag1 < mag2)) begin
                        state_d  = DIV_DONE;
                        done_d   = 1'b1;
                        cnt_d    = '0;
                        result_d = {operand1, ((operand2 == '0) ? ALL_ONES : {WIDTH{1'b0}})};
                    end
`endif
                end
            end

            DIV_BUSY: begin
                if (cancel) begin
                    state_d = DIV_IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end else begin
                    rem_d = rem_iter;
                    dvd_d = dvd_iter;
                    cnt_d = cnt_q - ITER_CNT_W'(1);
                    if (cnt_q == ITER_CNT_W'(1)) begin
                        state_d  = DIV_DONE;
                        done_d   = 1'b1;
                        result_d = divz_q ? {op1_q, ALL_ONES} : {rem_fix, quot_fix};
                    end
                end
            end

            DIV_DONE: begin
                state_d = DIV_IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = DIV_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= DIV_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            dvd_q    <= '0;
            dsr_q    <= '0;
            op1_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            divz_q   <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            dvd_q    <= dvd_d;
            dsr_q    <= dsr_d;
            op1_q    <= op1_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            divz_q   <= divz_d;
            result_q <= result_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign result = result_q;
    assign done   = done_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
// Directed bench for seq_divider. Expected results are queued at launch and
// popped by a monitor when done pulses; latency, cancel, reset and
// back-to-back behaviour are checked from the stimulus sequence.
// -----------------------------------------------------------------------------
module tb_seq_divider;
    import div_pkg::*;

    localparam int unsigned W = DIV_WIDTH;
`ifdef SEQ_DIV_FAST_PATH_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic           clk    = 1'b0;
    logic           rst    = 1'b0;
    logic           start  = 1'b0;
    logic           cancel = 1'b0;
    logic           uns    = 1'b0;
    logic [W-1:0]   op1    = '0;
    logic [W-1:0]   op2    = '0;
    logic [2*W-1:0] result;
    logic           done;
    logic           busy;

    seq_divider #(.WIDTH(W), .ITER_CNT_W(6)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .cancel        (cancel),
        .flag_unsigned (uns),
        .operand1      (op1),
        .operand2      (op2),
        .result        (result),
        .done          (done),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          total = 0;
    int          bad   = 0;
    logic [63:0] exp_q[$];
    string       tag_q[$];
    int          done_cnt = 0;
    int unsigned done_cyc = 0;
    logic        prev_done = 1'b0;
    logic [63:0] last_res = '0;
    logic [63:0] mon_e;
    string       mon_t;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Independent reference model using the language's own division
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic u);
        int sa, sb;
        if (b == 32'd0) return {a, DIVZ_QUOT};
        if (u) return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        sa = a;
        sb = b;
        return {32'(sa % sb), 32'(sa / sb)};
    endfunction

    function automatic int unsigned exp_lat(input logic [31:0] a, input logic [31:0] b, input logic u);
        logic [31:0] ma, mb;
        ma = (!u && a[31]) ? (32'd0 - a) : a;
        mb = (!u && b[31]) ? (32'd0 - b) : b;
        if (FAST && (b == 32'd0 || ma < mb)) return 0;
        return W;
    endfunction

    // Scoreboard side: each done pulse consumes one expected result
    always @(negedge clk) begin
        if (rst === 1'b1 && done === 1'b1) begin
            chk("done_one_cycle", {63'd0, prev_done}, 64'd0);
            done_cnt++;
            done_cyc = cyc;
            chk("sb_nonempty", {63'd0, exp_q.size() != 0}, 64'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                mon_t = tag_q.pop_front();
                chk({mon_t, "_result"}, result, mon_e);
            end
        end
        prev_done = (done === 1'b1);
    end

    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic u,
                          input logic [63:0] exp, input string tag);
        int          dc;
        int unsigned t0;
        bit          got;
        @(negedge clk);
        op1 = a; op2 = b; uns = u; start = 1'b1;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        dc = done_cnt;
        @(posedge clk);
        #1 t0 = cyc;
        @(negedge clk);
        #1;
        // Scramble inputs after launch; the divider must ignore them
        start = 1'b0; op1 = $urandom; op2 = $urandom; uns = ~u;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done_cnt != dc) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        chk({tag, "_done_seen"}, {63'd0, got}, 64'd1);
        if (got) chk({tag, "_latency"}, 64'(done_cyc - t0), 64'(exp_lat(a, b, u)));
        last_res = exp;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int          dc;
        int unsigned d1;
        int          unstable;
        bit          got;
        logic [31:0] ra, rb;
        logic        ru;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_result", result, 64'd0);
        chk("rst_done",   {63'd0, done}, 64'd0);
        chk("rst_busy",   {63'd0, busy}, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        do_div(32'd7,          32'd2,          1'b1, {32'h1, 32'h3},                 "divu_7_2");
        do_div(32'hFFFF_FFF9,  32'd2,          1'b0, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, "div_m7_2");
        do_div(32'd7,          32'hFFFF_FFFE,  1'b0, {32'h1, 32'hFFFF_FFFD},         "div_7_m2");
        do_div(32'h8000_0000,  32'hFFFF_FFFF,  1'b0, {32'h0, 32'h8000_0000},         "div_ovf");
        do_div(32'h1234_5678,  32'd0,          1'b1, {32'h1234_5678, 32'hFFFF_FFFF}, "divu_z");
        do_div(32'hFFFF_FFFB,  32'd0,          1'b0, {32'hFFFF_FFFB, 32'hFFFF_FFFF}, "div_z");
        do_div(32'd3,          32'd10,         1'b1, {32'h3, 32'h0},                 "divu_3_10");

        // cancel together with start in IDLE: no launch
        @(negedge clk);
        start = 1'b1; cancel = 1'b1;
        @(posedge clk);
        #1 chk("cancel_wins_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;

        // Back-to-back with start held high
        @(negedge clk);
        op1 = 32'd100; op2 = 32'd7; uns = 1'b1; start = 1'b1;
        exp_q.push_back({32'd2, 32'd14});
        tag_q.push_back("b2b_first");
        dc  = done_cnt;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt == dc + 1) begin
                got = 1'b1;
                break;
            end
        end
        chk("b2b_first_seen", {63'd0, got}, 64'd1);
        d1 = done_cyc;
        op1 = 32'd9; op2 = 32'd3;
        exp_q.push_back({32'd0, 32'd3});
        tag_q.push_back("b2b_second");
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        unstable = 0;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt == dc + 2) begin
                got = 1'b1;
                break;
            end
            if (result !== {32'd2, 32'd14}) unstable++;
        end
        chk("b2b_second_seen", {63'd0, got}, 64'd1);
        chk("b2b_gap", 64'(done_cyc - d1), 64'd34);
        chk("b2b_stable", 64'(unstable), 64'd0);
        last_res = {32'd0, 32'd3};

        // Cancel at iteration 10
        @(negedge clk);
        op1 = 32'd1000; op2 = 32'd3; uns = 1'b1; start = 1'b1;
        dc = done_cnt;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        cancel = 1'b1;
        @(posedge clk);
        #1 chk("cancel_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        cancel = 1'b0;
        repeat (40) @(negedge clk);
        chk("cancel_no_done", 64'(done_cnt), 64'(dc));
        chk("cancel_result",  result, last_res);

        // Reset at iteration 20
        @(negedge clk);
        op1 = 32'd1000; op2 = 32'd3; uns = 1'b1; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_result", result, 64'd0);
        chk("midrst_done",   {63'd0, done}, 64'd0);
        chk("midrst_busy",   {63'd0, busy}, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        do_div(32'd50, 32'hFFFF_FFF9, 1'b0, model(32'd50, 32'hFFFF_FFF9, 1'b0), "post_rst");

        // A handful of random operations against the reference model
        for (int k = 0; k < 6; k++) begin
            ra = $urandom;
            rb = (k < 3) ? ($urandom >> $urandom_range(0, 28)) : $urandom;
            ru = k[0];
            do_div(ra, rb, ru, model(ra, rb, ru), "rand");
        end

        repeat (3) @(negedge clk);
        chk("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
